// File: rtl/pu_spi_slave_driver_pkg.sv
// ---------------------------------------------------------------------------
// pu_spi_slave_driver_pkg
//   Shared definitions for the SPI slave bit engine.
//   - FSM state encoding (IDLE / FETCH / LOAD / SHIFT)
//   - synchroniser depth
//   - pin indices of the oversampled SPI inputs and their idle levels
// ---------------------------------------------------------------------------
package pu_spi_slave_driver_pkg;

   // Flip-flops in each input synchroniser (the edge-detect stage is extra).
   localparam int SYNC_STAGES = 2;

   // Bit positions of the oversampled SPI pins in the synchroniser bank.
   localparam int PIN_SCLK = 0;
   localparam int PIN_CS_N = 1;
   localparam int PIN_MOSI = 2;
   localparam int NUM_PINS = 3;

   // Reset level of each synchroniser. cs_n idles high, so its chain resets
   // to 1; otherwise reset release would look like a cs_n rising edge and
   // produce a spurious frame_done.
   localparam logic [NUM_PINS-1:0] PIN_RESET_LEVEL = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LOAD  = 2'd2,
      ST_SHIFT = 2'd3
   } state_t;

   // Width of a counter that must hold values 0 .. width-1.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/pu_spi_slave_driver_sync_edge.sv
// ---------------------------------------------------------------------------
// pu_spi_slave_driver_sync_edge
//   Brings one asynchronous SPI pin into the clk domain through a
//   SYNC_STAGES-deep flip-flop chain and derives single-cycle rise/fall
//   strobes by comparing the last synchroniser stage with one more stage.
// Ports
//   i_clk     in   system clock
//   i_rst_n   in   asynchronous active-low reset
//   i_async   in   asynchronous pin
//   o_level   out  synchronised pin level
//   o_rise    out  1-clk strobe, synchronised 0->1
//   o_fall    out  1-clk strobe, synchronised 1->0
// ---------------------------------------------------------------------------
module pu_spi_slave_driver_sync_edge
   import pu_spi_slave_driver_pkg::*;
#(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
         r_prev <= RESET_LEVEL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/pu_spi_slave_driver.sv
// ---------------------------------------------------------------------------
// pu_spi_slave_driver
//   SPI mode-0, MSB-first slave bit engine. Oversamples sclk/cs_n/mosi in the
//   clk domain, assembles MOSI words into rx-buffer write strobes, and fetches
//   tx-buffer words (oe strobe, data one clk later) to shift out on MISO.
// Ports
//   i_clk          in   system clock
//   i_rst_n        in   asynchronous active-low reset
//   i_sclk         in   SPI clock from master (async)
//   i_cs_n         in   SPI chip select, active low (async)
//   i_mosi         in   SPI master-out data (async)
//   o_miso         out  SPI master-in data, 0 when not selected
//   o_miso_oe      out  pad output enable, equals o_busy
//   o_rx_wr        out  1-clk write strobe to the rx buffer
//   o_rx_data      out  received word, valid with o_rx_wr
//   i_rx_full      in   rx buffer full
//   o_tx_oe        out  1-clk read strobe to the tx buffer
//   i_tx_data      in   tx buffer data, valid 1 clk after o_tx_oe
//   o_busy         out  frame in progress
//   o_frame_done   out  1-clk pulse when the frame ends (cs_n rise)
//   o_overflow     out  sticky: a received word was dropped (rx full)
// ---------------------------------------------------------------------------
module pu_spi_slave_driver
   import pu_spi_slave_driver_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_sclk,
   input  logic                  i_cs_n,
   input  logic                  i_mosi,
   output logic                  o_miso,
   output logic                  o_miso_oe,
   output logic                  o_rx_wr,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   input  logic                  i_rx_full,
   output logic                  o_tx_oe,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_overflow
);

   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   // ------------------------------------------------------------------
   // Input synchronisers, one per SPI pin
   // ------------------------------------------------------------------
   logic [NUM_PINS-1:0] w_pin_async;
   logic [NUM_PINS-1:0] w_level;
   logic [NUM_PINS-1:0] w_rise;
   logic [NUM_PINS-1:0] w_fall;

   assign w_pin_async = {i_mosi, i_cs_n, i_sclk};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PINS; gi++) begin : g_sync
         pu_spi_slave_driver_sync_edge #(
            .RESET_LEVEL (PIN_RESET_LEVEL[gi])
         ) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_async (w_pin_async[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
         );
      end
   endgenerate

   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_rise;
   logic w_cs_fall;
   logic w_mosi;

   assign w_sclk_rise = w_rise[PIN_SCLK];
   assign w_sclk_fall = w_fall[PIN_SCLK];
   assign w_cs_rise   = w_rise[PIN_CS_N];
   assign w_cs_fall   = w_fall[PIN_CS_N];
   // mosi and sclk travel through identical pipelines, so the synchronised
   // mosi level seen with the sclk rise strobe is the bit the master set up.
   assign w_mosi      = w_level[PIN_MOSI];

   // Strobes that this engine has no use for.
   logic w_unused;
   assign w_unused = &{1'b0, w_level[PIN_SCLK], w_level[PIN_CS_N],
                       w_rise[PIN_MOSI], w_fall[PIN_MOSI]};

   // ------------------------------------------------------------------
   // Bit engine FSM
   // ------------------------------------------------------------------
   state_t                r_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [DATA_WIDTH-1:0] r_tx_next;
   logic                  r_word_end;   // next sclk fall starts a new tx word
   logic                  r_tx_oe_d1;   // tx buffer data valid this clk
   logic                  r_miso;
   logic                  r_busy;
   logic                  r_rx_wr;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic                  r_tx_oe;
   logic                  r_frame_done;
   logic                  r_overflow;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_rx_shift   <= '0;
         r_tx_shift   <= '0;
         r_tx_next    <= '0;
         r_word_end   <= 1'b0;
         r_tx_oe_d1   <= 1'b0;
         r_miso       <= 1'b0;
         r_busy       <= 1'b0;
         r_rx_wr      <= 1'b0;
         r_rx_data    <= '0;
         r_tx_oe      <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_rx_wr      <= 1'b0;
         r_tx_oe      <= 1'b0;
         r_frame_done <= 1'b0;
         r_tx_oe_d1   <= r_tx_oe;

         if (w_cs_rise) begin
            // End of frame wins over everything, including a final sclk
            // rise in the same clk: any partial word is discarded.
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_miso       <= 1'b0;
            r_bit_cnt    <= '0;
            r_word_end   <= 1'b0;
            r_state      <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_cs_fall) begin
                     r_tx_oe    <= 1'b1;
                     r_overflow <= 1'b0;
                     r_busy     <= 1'b1;
                     r_rx_shift <= '0;
                     r_state    <= ST_FETCH;
                  end
               end

               ST_FETCH: begin
                  r_state <= ST_LOAD;
               end

               ST_LOAD: begin
                  r_tx_shift <= i_tx_data;
                  r_miso     <= i_tx_data[DATA_WIDTH-1];
                  r_bit_cnt  <= '0;
                  r_word_end <= 1'b0;
                  r_state    <= ST_SHIFT;
               end

               ST_SHIFT: begin
                  // Word requested on the previous word's last rise arrives
                  // two clks after that rise; park it until the next fall.
                  if (r_tx_oe_d1) begin
                     r_tx_next <= i_tx_data;
                  end

                  if (w_sclk_rise) begin
                     r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                     if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt  <= '0;
                        r_word_end <= 1'b1;
                        r_tx_oe    <= 1'b1;
                        if (i_rx_full) begin
                           r_overflow <= 1'b1;
                        end else begin
                           r_rx_wr   <= 1'b1;
                           r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     end
                  end else if (w_sclk_fall) begin
                     if (r_word_end) begin
                        r_tx_shift <= r_tx_next;
                        r_miso     <= r_tx_next[DATA_WIDTH-1];
                        r_word_end <= 1'b0;
                     end else begin
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                        r_miso     <= r_tx_shift[DATA_WIDTH-2];
                     end
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_miso       = r_miso;
   assign o_miso_oe    = r_busy;
   assign o_busy       = r_busy;
   assign o_rx_wr      = r_rx_wr;
   assign o_rx_data    = r_rx_data;
   assign o_tx_oe      = r_tx_oe;
   assign o_frame_done = r_frame_done;
   assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_pu_spi_slave_driver.sv
// ---------------------------------------------------------------------------
// tb_pu_spi_slave_driver
//   Directed bench: an SPI mode-0 master task, a registered tx-buffer model,
//   and a negedge monitor logging rx writes, tx fetches and frame_done pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pu_spi_slave_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic       rx_wr;
   logic [7:0] rx_data;
   logic       rx_full = 1'b0;
   logic       tx_oe;
   logic [7:0] tx_data = 8'h00;
   logic       busy;
   logic       frame_done;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;
   bit done    = 1'b0;

   always #5 clk = ~clk;

   pu_spi_slave_driver #(.DATA_WIDTH(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_sclk       (sclk),
      .i_cs_n       (cs_n),
      .i_mosi       (mosi),
      .o_miso       (miso),
      .o_miso_oe    (miso_oe),
      .o_rx_wr      (rx_wr),
      .o_rx_data    (rx_data),
      .i_rx_full    (rx_full),
      .o_tx_oe      (tx_oe),
      .i_tx_data    (tx_data),
      .o_busy       (busy),
      .o_frame_done (frame_done),
      .o_overflow   (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end else begin
         $display("PASS %s value=%0h", tag, obs);
      end
   endtask

   initial begin
      #2_000_000;
      if (!done) begin
         n_tests++;
         n_fail++;
         $error("FAIL watchdog: simulation did not complete in time");
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   // Tx buffer model: registered read, data valid one clk after oe.
   logic [7:0] tx_mem [64];
   int         tx_ptr = 0;
   always @(posedge clk) begin
      if (tx_oe) begin
         tx_data <= tx_mem[tx_ptr];
         tx_ptr  <= tx_ptr + 1;
      end
   end

   // Monitor
   logic [7:0] rx_log [64];
   int         rx_cnt = 0;
   int         fd_cnt = 0;
   always @(negedge clk) begin
      if (rx_wr) begin
         rx_log[rx_cnt] = rx_data;
         rx_cnt++;
      end
      if (frame_done) fd_cnt++;
   end

   // SPI mode-0 master: mosi changes on sclk fall, miso sampled before rise.
   task automatic xfer(input int nbits, input int half, input int setup,
                       input logic [31:0] mo, output logic [31:0] mi);
      mi = '0;
      @(negedge clk);
      cs_n = 1'b0;
      mosi = mo[31];
      repeat (setup) @(negedge clk);
      check("busy_in_frame", busy, 1'b1);
      check("miso_oe_in_frame", miso_oe, 1'b1);
      for (int i = 0; i < nbits; i++) begin
         mi   = {mi[30:0], miso};
         sclk = 1'b1;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
         if (i + 1 < nbits) mosi = mo[30 - i];
         repeat (half) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   logic [31:0] mi;
   int          b_oe, b_rx, b_fd;

   initial begin
      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      check("rst_miso", miso, 1'b0);
      check("rst_miso_oe", miso_oe, 1'b0);
      check("rst_rx_wr", rx_wr, 1'b0);
      check("rst_tx_oe", tx_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_fd_cnt", fd_cnt, 0);
      check("post_rst_oe_cnt", tx_ptr, 0);
      check("post_rst_busy", busy, 1'b0);

      // ---------------- 1-word frame ----------------
      b_oe = tx_ptr; b_rx = rx_cnt; b_fd = fd_cnt;
      tx_mem[b_oe] = 8'h3C; tx_mem[b_oe + 1] = 8'h99;
      xfer(8, 8, 8, 32'hA500_0000, mi);
      check("w1_rx_count", rx_cnt - b_rx, 1);
      check("w1_rx_data", rx_log[b_rx], 8'hA5);
      check("w1_miso_word", mi[7:0], 8'h3C);
      check("w1_tx_oe_count", tx_ptr - b_oe, 2);
      check("w1_frame_done", fd_cnt - b_fd, 1);
      check("w1_miso_idle", miso, 1'b0);
      check("w1_miso_oe_idle", miso_oe, 1'b0);

      // ---------------- 4-word frame, sclk = 8 clk ----------------
      b_oe = tx_ptr; b_rx = rx_cnt; b_fd = fd_cnt;
      tx_mem[b_oe]     = 8'hC1; tx_mem[b_oe + 1] = 8'h52;
      tx_mem[b_oe + 2] = 8'hE7; tx_mem[b_oe + 3] = 8'h0F;
      tx_mem[b_oe + 4] = 8'h77;
      xfer(32, 4, 8, 32'h0102_0304, mi);
      check("w4_rx_count", rx_cnt - b_rx, 4);
      check("w4_rx0", rx_log[b_rx], 8'h01);
      check("w4_rx1", rx_log[b_rx + 1], 8'h02);
      check("w4_rx2", rx_log[b_rx + 2], 8'h03);
      check("w4_rx3", rx_log[b_rx + 3], 8'h04);
      check("w4_miso_words", mi, 32'hC152_E70F);
      check("w4_tx_oe_count", tx_ptr - b_oe, 5);
      check("w4_frame_done", fd_cnt - b_fd, 1);

      // ---------------- aborted after 3 bits ----------------
      b_oe = tx_ptr; b_rx = rx_cnt; b_fd = fd_cnt;
      tx_mem[b_oe] = 8'hE0;
      xfer(3, 4, 8, 32'hA000_0000, mi);
      check("ab_rx_count", rx_cnt - b_rx, 0);
      check("ab_miso_bits", mi[2:0], 3'b111);
      check("ab_tx_oe_count", tx_ptr - b_oe, 1);
      check("ab_frame_done", fd_cnt - b_fd, 1);
      check("ab_miso", miso, 1'b0);
      check("ab_miso_oe", miso_oe, 1'b0);

      // ---------------- rx_full during 2-word frame ----------------
      b_oe = tx_ptr; b_rx = rx_cnt;
      tx_mem[b_oe] = 8'h11; tx_mem[b_oe + 1] = 8'h22; tx_mem[b_oe + 2] = 8'h33;
      rx_full = 1'b1;
      xfer(16, 4, 8, 32'hDEAD_0000, mi);
      check("full_rx_count", rx_cnt - b_rx, 0);
      check("full_overflow", overflow, 1'b1);
      check("full_miso_words", mi[15:0], 16'h1122);
      rx_full = 1'b0;
      b_oe = tx_ptr; b_rx = rx_cnt;
      tx_mem[b_oe] = 8'h44; tx_mem[b_oe + 1] = 8'h55;
      xfer(8, 4, 8, 32'h5A00_0000, mi);
      check("clr_overflow", overflow, 1'b0);
      check("clr_rx_count", rx_cnt - b_rx, 1);
      check("clr_rx_data", rx_log[b_rx], 8'h5A);

      // ---------------- minimum timing ----------------
      b_oe = tx_ptr; b_rx = rx_cnt;
      tx_mem[b_oe] = 8'h81; tx_mem[b_oe + 1] = 8'h7E; tx_mem[b_oe + 2] = 8'h00;
      xfer(16, 4, 6, 32'h963F_0000, mi);
      check("min_rx_count", rx_cnt - b_rx, 2);
      check("min_rx0", rx_log[b_rx], 8'h96);
      check("min_rx1", rx_log[b_rx + 1], 8'h3F);
      check("min_miso_words", mi[15:0], 16'h817E);

      // ---------------- reset during bit 5 ----------------
      b_oe = tx_ptr; b_rx = rx_cnt; b_fd = fd_cnt;
      tx_mem[b_oe] = 8'hF0;
      @(negedge clk);
      cs_n = 1'b0;
      mosi = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mr_miso", miso, 1'b0);
      check("mr_miso_oe", miso_oe, 1'b0);
      check("mr_busy", busy, 1'b0);
      check("mr_rx_data", rx_data, 8'h00);
      check("mr_overflow", overflow, 1'b0);
      check("mr_tx_oe", tx_oe, 1'b0);
      check("mr_rx_wr", rx_wr, 1'b0);
      check("mr_frame_done", frame_done, 1'b0);
      @(negedge clk);
      sclk = 1'b0;
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("mr_rx_count", rx_cnt - b_rx, 0);
      check("mr_fd_count", fd_cnt - b_fd, 0);
      check("mr_busy_after", busy, 1'b0);

      // ---------------- clean frame after reset ----------------
      b_oe = tx_ptr; b_rx = rx_cnt; b_fd = fd_cnt;
      tx_mem[b_oe] = 8'h3C; tx_mem[b_oe + 1] = 8'h66;
      xfer(8, 4, 8, 32'hC300_0000, mi);
      check("pr_rx_count", rx_cnt - b_rx, 1);
      check("pr_rx_data", rx_log[b_rx], 8'hC3);
      check("pr_miso_word", mi[7:0], 8'h3C);
      check("pr_tx_oe_count", tx_ptr - b_oe, 2);
      check("pr_frame_done", fd_cnt - b_fd, 1);

      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
